byte_fifo: RTL and testbench
============================

BYTE_FIFO -- requirements
Module: byte_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of contents and checksum.
REQ-006 SHALL have port in_valid  input  1  upstream byte present.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port in_data  input  WIDTH  upstream byte.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_ready  input  1  downstream (delay chain) accepts the head.
REQ-011 SHALL have port out_data  output  WIDTH  head entry.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port max_level  output  $clog2(DEPTH)+1  high-water mark since reset/flush.
REQ-014 SHALL have port checksum  output  WIDTH  modulo-2^WIDTH sum of all popped bytes.

Function
REQ-015 SHALL push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (level != DEPTH) from registered state only; no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (level != 0) and out_data = storage[rd_ptr] from registers; no bypass from in_data.
REQ-018 SHALL give latency of exactly 1 cycle: byte pushed at edge N is visible on out_data with out_valid after edge N.
REQ-019 SHALL allow simultaneous push and pop when 0 < level < DEPTH; level unchanged, both pointers advance.
REQ-020 SHALL, at level == DEPTH, refuse push (in_ready=0) even if a pop occurs in that cycle; level becomes DEPTH-1.
REQ-021 SHALL, at level == 0, ignore out_ready; a push that cycle gives level 1.
REQ-022 SHALL wrap rd_ptr/wr_ptr modulo DEPTH; order preserved strictly FIFO.
REQ-023 SHALL update checksum <= checksum + out_data on each pop, truncated to WIDTH bits.
REQ-024 SHALL update max_level <= max(max_level, next level) every cycle.
REQ-025 SHALL, when flush=1, set level, pointers, checksum and max_level to 0 at the next edge, overriding any push/pop that cycle.
REQ-026 SHALL leave storage contents unchanged on flush; they are unobservable until rewritten.

Reset
REQ-027 SHALL, while rst_n=0, force level=0, max_level=0, checksum=0, pointers=0, out_valid=0, in_ready=1 immediately, without waiting for clk.
REQ-028 SHALL discard in-flight data on reset mid-operation; first pop after release returns the first byte pushed after release.
REQ-029 SHALL resume pushing on the first posedge clk after rst_n rises.
REQ-030 SHALL leave out_data undefined-but-stable (no X required to be 0) while out_valid=0.

Verification
REQ-031 SHALL cover: push 0x11,0x22,0x33 with out_ready=0 -> level=3, out_data=0x11; then out_ready=1 for 3 cycles -> pops 0x11,0x22,0x33, checksum=0x66, max_level=3.
REQ-032 SHALL cover: DEPTH=4, push 5 bytes back-to-back with out_ready=0 -> in_ready=0 after 4th, 5th not accepted, level=4; one pop while in_valid=1 -> no push that cycle, level=3.
REQ-033 SHALL cover: continuous in_valid/out_ready=1 for 20 bytes 0..19 -> level steady at 1 after first cycle, out order 0..19, checksum=190 mod 256=0xBE, pointers wrap 5 times.
REQ-034 SHALL cover: level=2, assert flush with concurrent push and pop -> next cycle level=0, checksum=0, max_level=0, out_valid=0.
REQ-035 SHALL cover: level=3, drop rst_n between edges -> out_valid=0, in_ready=1 before next posedge; after release push 0xA5 -> popped byte is 0xA5.
REQ-036 SHALL cover: pop 0xFF then 0x02 -> checksum wraps to 0x01.

Source files
------------

// File: rtl/byte_fifo.sv
// Byte FIFO with registered outputs, one-cycle push-to-head latency, running checksum of
// popped bytes and an occupancy high-water mark. Storage is never reset or flushed.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     max_level,
    output logic [WIDTH-1:0]           checksum
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push;
    logic             pop;
    logic [LW-1:0]    level_next;
    logic [LW-1:0]    max_next;

    // Handshake qualifiers come only from registered level, never from the other side.
    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign out_data  = storage[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
        max_next = (level_next > max_level) ? level_next : max_level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            max_level <= '0;
            checksum  <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            max_level <= '0;
            checksum  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                checksum <= checksum + out_data;
            end
            level     <= level_next;
            max_level <= max_next;
        end
    end

    // Data array has no reset; stale entries stay hidden behind level.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_byte_fifo.sv
// Directed self-checking bench for byte_fifo (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_byte_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic [2:0] max_level;
    logic [7:0] checksum;

    int n_chk = 0;
    int n_bad = 0;

    byte_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .max_level (max_level),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one clock edge, return 1 time unit after it.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_level", 32'(level), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_max", 32'(max_level), 32'd0);
        check("rst_sum", 32'(checksum), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Three pushes, then drain them
        step(1'b1, 8'h11, 1'b0, 1'b0);
        check("lat1_valid", 32'(out_valid), 32'd1);
        check("lat1_data", 32'(out_data), 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("t1_level", 32'(level), 32'd3);
        check("t1_head", 32'(out_data), 32'h11);
        check("t1_pop0", 32'(out_data), 32'h11);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_pop1", 32'(out_data), 32'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_pop2", 32'(out_data), 32'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_empty", 32'(out_valid), 32'd0);
        check("t1_sum", 32'(checksum), 32'h66);
        check("t1_max", 32'(max_level), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_empty_pop_ignored", 32'(checksum), 32'h66);
        check("t1_empty_level", 32'(level), 32'd0);
        do_flush();
        check("flush_max", 32'(max_level), 32'd0);

        // Fill to full, overflow attempt, pop while in_valid held
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("t2_full_ready", 32'(in_ready), 32'd0);
        check("t2_full_level", 32'(level), 32'd4);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        check("t2_overflow_level", 32'(level), 32'd4);
        step(1'b1, 8'h06, 1'b1, 1'b0);
        check("t2_pop_at_full_level", 32'(level), 32'd3);
        check("t2_ready_again", 32'(in_ready), 32'd1);
        check("t2_sum1", 32'(checksum), 32'h01);
        for (int i = 2; i <= 4; i++) begin
            check("t2_drain", 32'(out_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("t2_empty", 32'(out_valid), 32'd0);
        check("t2_sum", 32'(checksum), 32'h0A);
        check("t2_max", 32'(max_level), 32'd4);
        do_flush();

        // Streaming 0..19 with both sides always ready
        for (int i = 0; i < 20; i++) begin
            if (i > 0) check("t3_head", 32'(out_data), 32'(i - 1));
            step(1'b1, 8'(i), 1'b1, 1'b0);
            check("t3_level", 32'(level), 32'd1);
        end
        check("t3_last_head", 32'(out_data), 32'd19);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_sum", 32'(checksum), 32'hBE);
        check("t3_level_end", 32'(level), 32'd0);
        check("t3_max", 32'(max_level), 32'd1);
        do_flush();

        // Flush overrides concurrent push and pop
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_pre_level", 32'(level), 32'd2);
        check("t4_pre_sum", 32'(checksum), 32'h40);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check("t4_level", 32'(level), 32'd0);
        check("t4_sum", 32'(checksum), 32'd0);
        check("t4_max", 32'(max_level), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-operation
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check("t5_pre_level", 32'(level), 32'd3);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_ready", 32'(in_ready), 32'd1);
        check("t5_async_level", 32'(level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("t5_head", 32'(out_data), 32'hA5);
        check("t5_level", 32'(level), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_sum", 32'(checksum), 32'hA5);
        do_flush();

        // Checksum wrap
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0);
        check("t6_sum_ff", 32'(checksum), 32'hFF);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_sum_wrap", 32'(checksum), 32'h01);
        check("t6_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
